// File: rtl/uart_rx_core.sv
// UART receive core: oversamples RX_IN, 2-of-3 majority per bit, recovers
// start / WIDTH data (LSB first) / optional parity / stop frames.
module uart_rx_core #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [5:0]       PRESCALE,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_edge;
  logic [5:0]       r_prescale;
  logic [BW-1:0]    r_bit;
  logic             r_par_en;
  logic             r_par_typ;
  logic             r_s0;
  logic             r_s1;
  logic             r_par_bad;
  logic             r_armed;
  logic [WIDTH-1:0] r_shift;

  logic [5:0]       w_half;
  logic             w_last;
  logic             w_decide;
  logic             w_maj;
  logic             w_start;
  logic             w_last_bit;

  assign w_half     = {1'b0, r_prescale[5:1]};
  assign w_last     = (r_edge == r_prescale - 6'd1);
  assign w_decide   = (r_edge == w_half + 6'd1);
  // Third sample is the live input at the decision edge.
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
  assign w_start    = (r_state == S_IDLE) && !RX_IN && r_armed;
  assign w_last_bit = (r_bit == BW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start) w_next = S_START;
      S_START: begin
        if (w_decide && w_maj) w_next = S_IDLE;
        else if (w_last)       w_next = S_DATA;
      end
      S_DATA:   if (w_last && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_last) w_next = S_STOP;
      S_STOP:   if (w_decide) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge     <= '0;
      r_bit      <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_par_bad  <= 1'b0;
      r_armed    <= 1'b1;
      r_shift    <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (RX_IN) r_armed <= 1'b1;

      if (r_state == S_IDLE) begin
        r_edge <= '0;
        r_bit  <= '0;
        // Detect cycle counts as edge 0, so the counter resumes at 1.
        if (w_start) begin
          r_edge     <= 6'd1;
          r_prescale <= PRESCALE;
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_par_bad  <= 1'b0;
        end
      end else begin
        r_edge <= w_last ? '0 : r_edge + 6'd1;
        if (r_edge == w_half - 6'd1) r_s0 <= RX_IN;
        if (r_edge == w_half)        r_s1 <= RX_IN;

        if (r_state == S_DATA && w_last)
          r_bit <= w_last_bit ? '0 : r_bit + 1'b1;

        if (w_decide) begin
          case (r_state)
            S_DATA:   r_shift   <= {w_maj, r_shift[WIDTH-1:1]};
            S_PARITY: r_par_bad <= (w_maj != (^r_shift ^ r_par_typ));
            S_STOP: begin
              STP_ERR    <= !w_maj;
              PAR_ERR    <= r_par_bad;
              DATA_VALID <= w_maj && !r_par_bad;
              if (w_maj && !r_par_bad) P_DATA <= r_shift;
              if (!w_maj) r_armed <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: per-cycle line waveforms are built from frame
// descriptions and the observed output pulses are compared to predicted events.
module tb_uart_rx_core;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RX_IN = 1'b1;
  logic [5:0]   PRESCALE = 6'd8;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_ERR;
  logic         STP_ERR;

  uart_rx_core #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned  cyc;
    logic [2:0]   flags;   // {valid, parity error, stop error}
    logic [W-1:0] data;
  } ev_t;

  ev_t          ev_q[$];
  ev_t          exp_q[$];
  logic         wave[$];
  logic [W-1:0] model_pdata;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Append one frame using the current PRESCALE/PAR_EN/PAR_TYP settings.
  task automatic add_frame(input logic [W-1:0] data, input logic par_bit,
                           input logic stop_bit, input int unsigned stop_len,
                           input bit expect_ev);
    int unsigned p, st, nbits, ones;
    logic        good_par, perr, serr, ok;
    p     = int'(PRESCALE);
    st    = wave.size();
    nbits = 1 + W + (PAR_EN ? 1 : 0);
    ones  = 0;
    for (int unsigned k = 0; k < p; k++) wave.push_back(1'b0);
    for (int unsigned b = 0; b < W; b++) begin
      if (data[b]) ones++;
      for (int unsigned k = 0; k < p; k++) wave.push_back(data[b]);
    end
    if (PAR_EN)
      for (int unsigned k = 0; k < p; k++) wave.push_back(par_bit);
    for (int unsigned k = 0; k < stop_len; k++) wave.push_back(stop_bit);
    good_par = ((ones % 2) == 1) ^ PAR_TYP;
    perr     = PAR_EN && (par_bit != good_par);
    serr     = !stop_bit;
    ok       = !perr && !serr;
    if (expect_ev) begin
      if (ok) model_pdata = data;
      exp_q.push_back('{cyc: st + nbits * p + p / 2 + 2, flags: {ok, perr, serr}, data: model_pdata});
    end
  endtask

  task automatic add_idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) wave.push_back(1'b1);
  endtask

  task automatic play(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (DATA_VALID || PAR_ERR || STP_ERR)
        ev_q.push_back('{cyc: i, flags: {DATA_VALID, PAR_ERR, STP_ERR}, data: P_DATA});
      RX_IN = (i < wave.size()) ? wave[i] : 1'b1;
    end
  endtask

  task automatic compare(input string tag);
    int unsigned n;
    chk({tag, " events"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, " cycle"}, ev_q[i].cyc, exp_q[i].cyc);
      chk({tag, " flags"}, 32'(ev_q[i].flags), 32'(exp_q[i].flags));
      chk({tag, " data"}, 32'(ev_q[i].data), 32'(exp_q[i].data));
    end
    chk({tag, " hold"}, 32'(P_DATA), 32'(model_pdata));
    ev_q.delete();
    exp_q.delete();
    wave.delete();
  endtask

  task automatic run(input string tag);
    play(wave.size() + 24);
    compare(tag);
  endtask

  initial begin
    int unsigned st;
    logic [W-1:0] d;

    model_pdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset p_data", 32'(P_DATA), 32'h0);
    chk("reset valid", 32'(DATA_VALID), 32'h0);
    chk("reset par_err", 32'(PAR_ERR), 32'h0);
    chk("reset stp_err", 32'(STP_ERR), 32'h0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Good frame, even parity: pulse predicted at cycle 86.
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    add_frame(8'hA5, 1'b0, 1'b1, 8, 1);
    chk("t1 model cycle", exp_q[0].cyc, 86);
    run("t1");

    // Parity errors under even parity, then odd parity accepted.
    add_frame(8'hA5, 1'b1, 1'b1, 8, 1);
    add_frame(8'h3E, 1'b0, 1'b1, 8, 1);
    run("t2 even");
    PAR_TYP = 1'b1;
    add_frame(8'hA5, 1'b1, 1'b1, 8, 1);
    run("t2 odd");

    // No parity, prescale sweep.
    PAR_EN = 1'b0; PRESCALE = 6'd16;
    add_frame(8'h3C, 1'b0, 1'b1, 16, 1);
    chk("t3 p16 model cycle", exp_q[0].cyc, 154);
    run("t3 p16");
    PRESCALE = 6'd32;
    add_frame(8'h3C, 1'b0, 1'b1, 32, 1);
    chk("t3 p32 model cycle", exp_q[0].cyc, 306);
    run("t3 p32");

    // Short low glitch on idle line, then a good frame.
    PRESCALE = 6'd16;
    add_idle(10);
    wave.push_back(1'b0);
    wave.push_back(1'b0);
    add_idle(40);
    add_frame(W'($urandom_range(1, 255)), 1'b0, 1'b1, 16, 1);
    run("t4 start glitch");

    // Single inverted sample at the centre of data bit 3.
    d  = W'($urandom_range(0, 255));
    st = wave.size();
    add_frame(d, 1'b0, 1'b1, 16, 1);
    wave[st + 4 * 16 + 8] = ~wave[st + 4 * 16 + 8];
    run("t4 data glitch");

    // Stop error followed by a held-low break, then recovery.
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    add_frame(8'h55, 1'b0, 1'b0, 8 + 100, 1);
    add_idle(5);
    add_frame(8'h81, 1'b0, 1'b1, 8, 1);
    run("t5 break");

    // Back-to-back frames with no idle gap.
    PRESCALE = 6'd16; PAR_TYP = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2; k++) begin
      d = W'($urandom_range(1, 255));
      add_frame(d, ^d ^ PAR_TYP, 1'b1, 16, 1);
    end
    run("t6 b2b");

    // Reset during data bits discards the frame and clears outputs.
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    add_frame(8'hC3, 1'b0, 1'b1, 8, 0);
    play(40);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst p_data", 32'(P_DATA), 32'h0);
    chk("rst valid", 32'(DATA_VALID), 32'h0);
    chk("rst par_err", 32'(PAR_ERR), 32'h0);
    chk("rst stp_err", 32'(STP_ERR), 32'h0);
    RST = 1'b0;
    RX_IN = 1'b1;
    model_pdata = '0;
    wave.delete();
    play(200);
    compare("t6 reset");

    // Randomized configurations and frames.
    for (int it = 0; it < 4; it++) begin
      case ($urandom_range(0, 2))
        0:       PRESCALE = 6'd8;
        1:       PRESCALE = 6'd16;
        default: PRESCALE = 6'd32;
      endcase
      PAR_EN  = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
        add_idle($urandom_range(0, 4));
        add_frame(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1,
                  int'(PRESCALE), 1);
      end
      run("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
